zero_run_expander: RTL
======================

# zero_run_expander

Streaming byte decoder that expands run-length-coded zero tokens back into a plain 8-bit byte stream. Each input token is either a literal byte, emitted once, or a zero run, emitted as N consecutive 0x00 bytes. It sits upstream of the zero-detection logic. Its output stream is the data that the zero detector flags byte by byte, so its zero runs must be bit-exact.

## Interface
- WIDTH, 8, data byte width; also the width of the run-length field.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active high.
- in_valid  input  1  a token is present on in_is_run/in_data.
- in_ready  output  1  block accepts the token this cycle.
- in_is_run  input  1  0 = literal token, 1 = zero-run token.
- in_data  input  WIDTH  literal value, or run length minus 1 (a run token emits in_data+1 zeros, 1..2^WIDTH).
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  downstream accepts the byte this cycle.
- out_data  output  WIDTH  expanded byte.
- run_active  output  1  the current out_data is a run byte with more run bytes still to follow (remain != 0).

## Operation
- Registers:
  - out_valid, out_data.
  - remain[WIDTH-1:0]: zeros still owed after the current out_data.
- Two states, derived from the registers:
  - EMPTY: out_valid=0.
  - EMIT: out_valid=1.
- Output handshake: fires when out_valid && out_ready. Input handshake: fires when in_valid && in_ready.
- in_ready = !rst && (!out_valid || (out_ready && remain==0)). It is combinational.
- Token accept (input handshake), next cycle:
  - out_valid=1.
  - Literal: out_data=in_data, remain=0.
  - Run: out_data=0, remain=in_data.
- Output handshake with remain!=0: remain decrements by 1, out_data stays 0, out_valid stays 1. Input is not accepted that cycle.
- Output handshake with remain==0 and no input handshake: out_valid goes to 0.
- Output handshake with remain==0 and an input handshake in the same cycle: the new token loads directly (no bubble).
- out_valid=1 with out_ready=0: out_data and remain hold unchanged, and in_ready=0.
- A literal 0x00 is legal. It emits exactly one zero byte, indistinguishable on the output from a run of length 1.
- run_active = out_valid && (remain != 0).
- The block emits no other values, does no reordering, and never drops data outside reset.

## Timing
- Reset values: out_valid=0, out_data=0, remain=0, run_active=0. in_ready=0 while rst=1, and 1 on the first cycle after rst deasserts.
- Latency: a token accepted at edge k gives its first output byte valid after edge k (one cycle).
- Throughput: one byte per cycle when out_ready is held high.
- A literal token occupies 1 output cycle. A run token with in_data=n occupies n+1 output cycles.
- Back-to-back tokens: the next token is accepted in the same cycle as the last byte's output handshake.
- Maximum run: in_data=2^WIDTH-1 gives 256 zeros. remain does not wrap, because it only decrements when non-zero.
- Reset mid-run: on the next edge the remaining zeros are discarded and out_valid goes to 0. No partial state survives.
- in_valid may change freely while in_ready=0. Tokens are sampled only on an input handshake.

## Test plan
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then release, with in_valid=0.
  - Required: out_valid=0, out_data=0x00, run_active=0 throughout; in_ready=0 during reset, 1 after.
- Literal stream with out_ready=1:
  - Stimulus: tokens L 0x01, L 0x02, L 0x0C, L 0x53 on consecutive cycles.
  - Required: out_data sequence 0x01, 0x02, 0x0C, 0x53 on 4 consecutive cycles, 1-cycle latency, in_ready stays 1.
- Run expansion:
  - Stimulus: R n=3, then L 0xA5, with out_ready=1.
  - Required: exactly 4 bytes of 0x00, with run_active=1,1,1,0; then 0xA5 on the 5th cycle with no gap; in_ready low for the first 3 run cycles.
- Backpressure:
  - Stimulus: R n=1; out_ready held 0 for 3 cycles after the first zero appears, then 1.
  - Required: out_data=0x00 and remain held while stalled, in_ready=0 while stalled; exactly 2 zeros total.
- Boundaries:
  - Stimulus: R n=0, then R n=255, then L 0x00.
  - Required: 1 zero, then 256 zeros, then 1 zero; 258 zeros total, with the output byte counter checked.
- Reset mid-run:
  - Stimulus: R n=10; assert rst after 4 zeros have been output.
  - Required: out_valid=0 on the next edge; after release, a new L 0x7F gives 0x7F with no stale zeros before it.

Source files
------------

// File: rtl/zero_run_expander_if.sv
// Token-in / byte-out handshake bundle for the zero-run expander.
// The master drives tokens and out_ready; the slave (the expander) drives everything else.
interface zero_run_expander_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_is_run;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             run_active;

  modport master (
    output in_valid, in_is_run, in_data, out_ready,
    input  in_ready, out_valid, out_data, run_active
  );

  modport slave (
    input  in_valid, in_is_run, in_data, out_ready,
    output in_ready, out_valid, out_data, run_active
  );
endinterface

// File: rtl/zero_run_expander.sv
// Expands literal / zero-run tokens into a byte stream; first byte one cycle after accept.
// Stalls hold out_data and the owed-zero count; a new token loads on the last byte's handshake.
module zero_run_expander #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  zero_run_expander_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    EMIT  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] remain_q, remain_d;
  logic [WIDTH-1:0] ld_data, ld_remain;
  logic             in_fire, out_fire, last_byte;

  assign last_byte    = (remain_q == '0);
  assign bus.in_ready = !rst && ((state_q == EMPTY) || (bus.out_ready && last_byte));
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = (state_q == EMIT) && bus.out_ready;

  // A run token owes in_data more zeros after the one it loads into out_data.
  assign ld_data   = bus.in_is_run ? '0 : bus.in_data;
  assign ld_remain = bus.in_is_run ? bus.in_data : '0;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    remain_d = remain_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d  = EMIT;
          data_d   = ld_data;
          remain_d = ld_remain;
        end
      end
      EMIT: begin
        if (out_fire) begin
          if (!last_byte) begin
            remain_d = remain_q - WIDTH'(1);
            data_d   = '0;
          end else if (in_fire) begin
            data_d   = ld_data;
            remain_d = ld_remain;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      remain_q <= remain_d;
    end
  end

  assign bus.out_valid  = (state_q == EMIT);
  assign bus.out_data   = data_q;
  assign bus.run_active = (state_q == EMIT) && !last_byte;

endmodule
